// File: rtl/morse_keyer.sv
// morse_keyer: queues Morse symbols in a small FIFO and keys them onto a line with unit-accurate timing
module morse_keyer #(
  parameter int UNIT = 70,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       signal,
  output logic       busy,
  output logic       bad_sym
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_occ = (AW+1)'(DEPTH);
  localparam logic [2:0] DIT = 3'd1;
  localparam logic [2:0] DAH = 3'd2;
  localparam logic [2:0] GAP = 3'd3;
  localparam logic [2:0] SPACE = 3'd4;
  // counters load duration-1 so a state lasting N cycles spans N edges
  localparam logic [8:0] len_1u = 9'(UNIT - 1);
  localparam logic [8:0] len_2u = 9'(2 * UNIT - 1);
  localparam logic [8:0] len_3u = 9'(3 * UNIT - 1);
  localparam logic [8:0] len_6u = 9'(6 * UNIT - 1);
  typedef enum logic [1:0] {IDLE, MARK, ELEM_GAP, EXTRA_GAP} state_t;
  state_t state, state_n;
  logic [8:0] cnt, cnt_n;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic [2:0] head;
  logic legal, take, push, pop, nonempty;
  assign sym_ready = (occ < full_occ) && !reset;
  assign take = sym_valid && sym_ready;
  assign legal = sym inside {DIT, DAH, GAP, SPACE};
  assign push = take && legal;
  assign nonempty = occ != '0;
  assign head = mem[rd_ptr];
  assign busy = (state != IDLE) || nonempty;
  // next state: a mark is always followed by one unit of low; any finished gap chains straight into the next queued symbol
  always_comb begin
    state_n = state;
    cnt_n = cnt - 9'd1;
    pop = 1'b0;
    if (state == MARK && cnt == '0) begin
      state_n = ELEM_GAP;
      cnt_n = len_1u;
    end else if (state == IDLE || cnt == '0) begin
      pop = nonempty;
      state_n = !nonempty ? IDLE : (head == DIT || head == DAH) ? MARK : EXTRA_GAP;
      cnt_n = !nonempty ? '0 : head == DIT ? len_1u : head == DAH ? len_3u : head == GAP ? len_2u : len_6u;
    end
  end
  // FSM, FIFO bookkeeping and registered line/bad-symbol outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      signal <= 1'b0;
      bad_sym <= 1'b0;
      occ <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      signal <= state_n == MARK;
      bad_sym <= take && !legal;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
    end
  end
  // symbol storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sym;
  end
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: table, directed and random checks of morse_keyer against a line-waveform model
module tb_morse_keyer;
  localparam int U = 70;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] sym = '0;
  logic sym_valid = 1'b0;
  logic sym_ready, signal, busy, bad_sym;
  int ntotal = 0;
  int nbad = 0;
  morse_keyer #(.UNIT(U), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .sym(sym), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .signal(signal), .busy(busy), .bad_sym(bad_sym)
  );
  always #5 clk = ~clk;
  function automatic void chk_b(string n, logic a, logic e);
    ntotal++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %b want %b at %0t", n, a, e, $time);
    end
  endfunction
  function automatic void chk_i(string n, int a, int e);
    ntotal++;
    if (a != e) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endfunction
  // Reference model: the line is the concatenation of per-symbol waveforms;
  // a queued symbol is started when the previous waveform has fully played out.
  logic [2:0] mq[$];
  bit line[$];
  bit e_bad = 0;
  bit tk;
  logic [2:0] ms;
  int on_len, off_len;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      line.delete();
      e_bad = 0;
    end else begin
      tk = sym_valid && (mq.size() < D);
      if (line.size() != 0) void'(line.pop_front());
      if (line.size() == 0 && mq.size() != 0) begin
        ms = mq.pop_front();
        on_len = ms == 3'd1 ? U : ms == 3'd2 ? 3 * U : 0;
        off_len = ms <= 3'd2 ? U : ms == 3'd3 ? 2 * U : 6 * U;
        repeat (on_len) line.push_back(1'b1);
        repeat (off_len) line.push_back(1'b0);
      end
      if (tk && sym >= 3'd1 && sym <= 3'd4) mq.push_back(sym);
      e_bad = tk && !(sym >= 3'd1 && sym <= 3'd4);
    end
  end
  always @(negedge clk) begin
    chk_b("signal", signal, line.size() != 0 && line[0]);
    chk_b("busy", busy, line.size() != 0 || mq.size() != 0);
    chk_b("sym_ready", sym_ready, !reset && mq.size() < D);
    chk_b("bad_sym", bad_sym, e_bad);
  end
  bit rec = 0;
  bit wave[$];
  int er[$];
  always @(negedge clk) if (rec && busy) wave.push_back(signal);
  task automatic check_runs(string n);
    int r[$];
    int i;
    i = 0;
    while (i < wave.size() && !wave[i]) i++;
    for (; i < wave.size(); i++)
      if (r.size() == 0 || wave[i] != wave[i-1]) r.push_back(1);
      else r[r.size()-1]++;
    chk_i({n, "_nruns"}, r.size(), er.size());
    for (int k = 0; k < r.size() && k < er.size(); k++) chk_i({n, "_run"}, r[k], er[k]);
  endtask
  task automatic offer(input logic [2:0] s);
    int g;
    g = 0;
    sym = s;
    sym_valid = 1'b1;
    while (!sym_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) chk_i("offer_wait", g, 0);
    @(negedge clk);
  endtask
  task automatic wait_idle(input string n);
    int g;
    g = 0;
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk_b(n, busy, 1'b0);
  endtask
  task automatic run_seq(input string n, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input int cnt);
    wave.delete();
    rec = 1;
    offer(a);
    if (cnt > 1) offer(b);
    if (cnt > 2) offer(c);
    sym_valid = 1'b0;
    wait_idle({n, "_idle"});
    rec = 0;
    check_runs(n);
  endtask
  typedef struct {
    logic [2:0] s;
    logic bad;
    int busy_cycles;
    int mark_cycles;
  } vec_t;
  vec_t tv[8];
  int bcnt, mcnt, g, nblk, hi;
  initial begin
    tv[0] = '{3'd0, 1'b1, 0, 0};
    tv[1] = '{3'd1, 1'b0, 1 + 2 * U, U};
    tv[2] = '{3'd2, 1'b0, 1 + 4 * U, 3 * U};
    tv[3] = '{3'd3, 1'b0, 1 + 2 * U, 0};
    tv[4] = '{3'd4, 1'b0, 1 + 6 * U, 0};
    tv[5] = '{3'd5, 1'b1, 0, 0};
    tv[6] = '{3'd6, 1'b1, 0, 0};
    tv[7] = '{3'd7, 1'b1, 0, 0};
    repeat (3) @(negedge clk);
    chk_b("rst_signal", signal, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_ready", sym_ready, 1'b0);
    chk_b("rst_bad", bad_sym, 1'b0);
    reset = 1'b0;
    #1 chk_b("ready_after_rst", sym_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sym = tv[i].s;
      sym_valid = 1'b1;
      @(negedge clk);
      sym_valid = 1'b0;
      chk_b("tbl_bad", bad_sym, tv[i].bad);
      bcnt = int'(busy);
      mcnt = int'(signal);
      @(negedge clk);
      chk_b("tbl_bad_len", bad_sym, 1'b0);
      g = 0;
      while (busy && g < 1000) begin
        bcnt++;
        mcnt += int'(signal);
        @(negedge clk);
        g++;
      end
      chk_i("tbl_busy_cycles", bcnt, tv[i].busy_cycles);
      chk_i("tbl_mark_cycles", mcnt, tv[i].mark_cycles);
    end
    er = '{U, U};
    run_seq("dit", 3'd1, 3'd0, 3'd0, 1);
    er = '{3 * U, U, U, U};
    run_seq("dah_dit", 3'd2, 3'd1, 3'd0, 2);
    er = '{U, 3 * U, U, U};
    run_seq("dit_gap_dit", 3'd1, 3'd3, 3'd1, 3);
    er = '{U, 7 * U, U, U};
    run_seq("dit_space_dit", 3'd1, 3'd4, 3'd1, 3);
    wave.delete();
    rec = 1;
    nblk = -1;
    for (int k = 0; k < 6; k++) begin
      sym = 3'd1;
      sym_valid = 1'b1;
      if (!sym_ready && nblk < 0) nblk = k;
      offer(3'd1);
    end
    sym_valid = 1'b0;
    chk_i("six_first_block", nblk, 5);
    chk_b("six_refull", sym_ready, 1'b0);
    wait_idle("six_idle");
    rec = 0;
    er.delete();
    repeat (12) er.push_back(U);
    check_runs("six_dits");
    offer(3'd2);
    offer(3'd1);
    offer(3'd1);
    sym_valid = 1'b0;
    repeat (98) @(negedge clk);
    chk_b("dah_mid_high", signal, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_b("async_signal", signal, 1'b0);
    chk_b("async_busy", busy, 1'b0);
    chk_b("async_ready", sym_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hi = 0;
    bcnt = 0;
    repeat (600) begin
      @(negedge clk);
      hi += int'(signal);
      bcnt += int'(busy);
    end
    chk_i("post_rst_marks", hi, 0);
    chk_i("post_rst_busy", bcnt, 0);
    for (int c = 0; c < 2500; c++) begin
      int r;
      r = $urandom_range(0, 11);
      sym = r < 8 ? 3'(r) : 3'(r - 7);
      sym_valid = $urandom_range(0, 2) != 0;
      @(negedge clk);
    end
    sym_valid = 1'b0;
    wait_idle("rand_drain");
    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end
endmodule
